idex_dispatch_queue: RTL and testbench

- Sits between decode (id) and the per-unit reservation stations.
- Buffers decoded instructions in program order: ex_unit, op, two tag/value operand pairs, ROB target.
- Snoops the common data bus (CDB) so buffered operands are filled while they wait.
- Issues the head entry to its reservation station when that station is not full, so a full station stalls only dispatch, not decode.

---
 rtl/idex_dispatch_queue.sv | 241 ++++++++++++++++++++++++
 tb/tb_idex_dispatch_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_dispatch_queue.sv
// ---------------------------------------------------------------------------
// idex_dispatch_queue
//
// In-order dispatch buffer between decode and the per-unit reservation
// stations. Each entry holds ex_unit, op, two tag/value operand pairs and the
// ROB target. The queue snoops the CDB so that waiting operands are resolved
// in place. The head entry issues whenever its reservation station has room.
// Because of this, a full station stalls dispatch but does not stall decode.
//
// Optional feature macro: IDEX_CDB_BYPASS_EN
//   When this macro is defined, the head operands are forwarded
//   combinationally from a matching CDB broadcast. The head therefore issues
//   already resolved in the same cycle as the broadcast.
//   When it is undefined, the out_* ports show only the stored values.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   flush                synchronous clear of pointers, count and valid bits
//   in_valid / in_ready  decode handshake
//   in_ex_unit, in_op, in_tag1/2, in_val1/2, in_target   incoming entry
//   cdb_valid, cdb_tag, cdb_val                          common data bus
//   rs_full              bit i set = reservation station i is full
//   out_valid            head entry presented
//   out_ex_unit, out_op, out_tag1/2, out_val1/2, out_target   head entry
//   count                occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module idex_dispatch_queue #(
    parameter int DEPTH    = 4,
    parameter int UNIT_NUM = 4,
    parameter int UNIT_W   = 2,
    parameter int OP_W     = 6,
    parameter int TAG_W    = 5,
    parameter int XLEN     = 32,
    parameter int ERR_UNIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [UNIT_W-1:0]        in_ex_unit,
    input  logic [OP_W-1:0]          in_op,
    input  logic [TAG_W-1:0]         in_tag1,
    input  logic [TAG_W-1:0]         in_tag2,
    input  logic [XLEN-1:0]          in_val1,
    input  logic [XLEN-1:0]          in_val2,
    input  logic [TAG_W-1:0]         in_target,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [XLEN-1:0]          cdb_val,
    input  logic [UNIT_NUM-1:0]      rs_full,
    output logic                     out_valid,
    output logic [UNIT_W-1:0]        out_ex_unit,
    output logic [OP_W-1:0]          out_op,
    output logic [TAG_W-1:0]         out_tag1,
    output logic [TAG_W-1:0]         out_tag2,
    output logic [XLEN-1:0]          out_val1,
    output logic [XLEN-1:0]          out_val2,
    output logic [TAG_W-1:0]         out_target,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam int                 CNT_W    = PTR_W + 1;
    localparam logic [UNIT_W-1:0]  ERR_CODE = UNIT_W'(ERR_UNIT);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    // Pointers and occupancy
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DEPTH-1:0]  r_vld;

    // Entry storage
    logic [UNIT_W-1:0] r_unit   [DEPTH];
    logic [OP_W-1:0]   r_op     [DEPTH];
    logic [TAG_W-1:0]  r_tag1   [DEPTH];
    logic [TAG_W-1:0]  r_tag2   [DEPTH];
    logic [XLEN-1:0]   r_val1   [DEPTH];
    logic [XLEN-1:0]   r_val2   [DEPTH];
    logic [TAG_W-1:0]  r_target [DEPTH];

    logic              w_push;
    logic              w_store;
    logic              w_pop;
    logic              w_blocked;
    logic              w_in_hit1;
    logic              w_in_hit2;
    logic [TAG_W-1:0]  w_in_tag1;
    logic [TAG_W-1:0]  w_in_tag2;
    logic [XLEN-1:0]   w_in_val1;
    logic [XLEN-1:0]   w_in_val2;
    logic [TAG_W-1:0]  w_head_tag1;
    logic [TAG_W-1:0]  w_head_tag2;
    logic [XLEN-1:0]   w_head_val1;
    logic [XLEN-1:0]   w_head_val2;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // A full queue refuses input even if the head leaves in the same cycle.
    // This keeps in_ready independent of rs_full.
    assign in_ready  = rst & (r_count != FULL_CNT);
    assign w_push    = in_valid & in_ready;
    // Undecodable entries complete the handshake but are dropped.
    assign w_store   = w_push & ~flush & (in_ex_unit != ERR_CODE);
    // The valid bit of the head is equivalent to count != 0.
    assign out_valid = (r_count != '0) & r_vld[r_rd_ptr];
    assign w_pop     = out_valid & ~w_blocked & ~flush;

    // Decode the head unit against rs_full with an explicit loop.
    // This keeps the logic legal for any UNIT_NUM / UNIT_W pairing.
    always_comb begin
        w_blocked = 1'b0;
        for (int unsigned i = 0; i < UNIT_NUM; i++) begin
            if (r_unit[r_rd_ptr] == UNIT_W'(i)) begin
                w_blocked = rs_full[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // CDB resolution of the entry being pushed
    // ------------------------------------------------------------------
    assign w_in_hit1 = cdb_valid & (in_tag1 != '0) & (in_tag1 == cdb_tag);
    assign w_in_hit2 = cdb_valid & (in_tag2 != '0) & (in_tag2 == cdb_tag);
    assign w_in_tag1 = w_in_hit1 ? '0      : in_tag1;
    assign w_in_tag2 = w_in_hit2 ? '0      : in_tag2;
    assign w_in_val1 = w_in_hit1 ? cdb_val : in_val1;
    assign w_in_val2 = w_in_hit2 ? cdb_val : in_val2;

    // ------------------------------------------------------------------
    // Pointer / count / valid-bit state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            // A store and a pop never hit the same slot.
            // A pop needs count != 0, and a store needs count != DEPTH.
            // Both pointers can therefore alias only when one of the two
            // operations is idle.
            if (w_store) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage with CDB snoop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_unit[i]   <= '0;
                r_op[i]     <= '0;
                r_tag1[i]   <= '0;
                r_tag2[i]   <= '0;
                r_val1[i]   <= '0;
                r_val2[i]   <= '0;
                r_target[i] <= '0;
            end
        end else if (!flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_store && (r_wr_ptr == PTR_W'(i))) begin
                    r_unit[i]   <= in_ex_unit;
                    r_op[i]     <= in_op;
                    r_tag1[i]   <= w_in_tag1;
                    r_tag2[i]   <= w_in_tag2;
                    r_val1[i]   <= w_in_val1;
                    r_val2[i]   <= w_in_val2;
                    r_target[i] <= in_target;
                end else begin
                    // Snoop every slot. Resolving an empty slot has no
                    // effect, because the slot is rewritten before it is
                    // read again.
                    if (cdb_valid && (r_tag1[i] != '0) && (r_tag1[i] == cdb_tag)) begin
                        r_tag1[i] <= '0;
                        r_val1[i] <= cdb_val;
                    end
                    if (cdb_valid && (r_tag2[i] != '0) && (r_tag2[i] == cdb_tag)) begin
                        r_tag2[i] <= '0;
                        r_val2[i] <= cdb_val;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Head outputs
    // ------------------------------------------------------------------
    assign out_ex_unit = r_unit[r_rd_ptr];
    assign out_op      = r_op[r_rd_ptr];
    assign out_target  = r_target[r_rd_ptr];
    assign count       = r_count;

    assign w_head_tag1 = r_tag1[r_rd_ptr];
    assign w_head_tag2 = r_tag2[r_rd_ptr];
    assign w_head_val1 = r_val1[r_rd_ptr];
    assign w_head_val2 = r_val2[r_rd_ptr];

    always_comb begin
        out_tag1 = w_head_tag1;
        out_tag2 = w_head_tag2;
        out_val1 = w_head_val1;
        out_val2 = w_head_val2;
`ifdef IDEX_CDB_BYPASS_EN
        if (cdb_valid && (w_head_tag1 != '0) && (w_head_tag1 == cdb_tag)) begin
            out_tag1 = '0;
            out_val1 = cdb_val;
        end
        if (cdb_valid && (w_head_tag2 != '0) && (w_head_tag2 == cdb_tag)) begin
            out_tag2 = '0;
            out_val2 = cdb_val;
        end
`else
        // The reservation station performs its own same-cycle CDB capture.
`endif
    end

endmodule

// File: tb/tb_idex_dispatch_queue.sv
// ---------------------------------------------------------------------------
// tb_idex_dispatch_queue
//
// Directed testbench for idex_dispatch_queue. Inputs are driven 1 ns after
// each rising edge. Outputs are sampled at that point, and combinational
// outputs are sampled 1 ns after the inputs change.
// ---------------------------------------------------------------------------
module tb_idex_dispatch_queue;

    localparam int DEPTH    = 4;
    localparam int UNIT_NUM = 4;
    localparam int UNIT_W   = 2;
    localparam int OP_W     = 6;
    localparam int TAG_W    = 5;
    localparam int XLEN     = 32;
    localparam int ERR_UNIT = 0;

`ifdef IDEX_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [UNIT_W-1:0]      in_ex_unit;
    logic [OP_W-1:0]        in_op;
    logic [TAG_W-1:0]       in_tag1;
    logic [TAG_W-1:0]       in_tag2;
    logic [XLEN-1:0]        in_val1;
    logic [XLEN-1:0]        in_val2;
    logic [TAG_W-1:0]       in_target;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [XLEN-1:0]        cdb_val;
    logic [UNIT_NUM-1:0]    rs_full;
    logic                   out_valid;
    logic [UNIT_W-1:0]      out_ex_unit;
    logic [OP_W-1:0]        out_op;
    logic [TAG_W-1:0]       out_tag1;
    logic [TAG_W-1:0]       out_tag2;
    logic [XLEN-1:0]        out_val1;
    logic [XLEN-1:0]        out_val2;
    logic [TAG_W-1:0]       out_target;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_errors = 0;

    idex_dispatch_queue #(
        .DEPTH    (DEPTH),
        .UNIT_NUM (UNIT_NUM),
        .UNIT_W   (UNIT_W),
        .OP_W     (OP_W),
        .TAG_W    (TAG_W),
        .XLEN     (XLEN),
        .ERR_UNIT (ERR_UNIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ex_unit  (in_ex_unit),
        .in_op       (in_op),
        .in_tag1     (in_tag1),
        .in_tag2     (in_tag2),
        .in_val1     (in_val1),
        .in_val2     (in_val2),
        .in_target   (in_target),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_val     (cdb_val),
        .rs_full     (rs_full),
        .out_valid   (out_valid),
        .out_ex_unit (out_ex_unit),
        .out_op      (out_op),
        .out_tag1    (out_tag1),
        .out_tag2    (out_tag2),
        .out_val1    (out_val1),
        .out_val2    (out_val2),
        .out_target  (out_target),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int unit, input int op, input int t1, input int v1,
                         input int t2, input int v2, input int tgt);
        in_valid   = 1'b1;
        in_ex_unit = UNIT_W'(unit);
        in_op      = OP_W'(op);
        in_tag1    = TAG_W'(t1);
        in_val1    = XLEN'(v1);
        in_tag2    = TAG_W'(t2);
        in_val2    = XLEN'(v2);
        in_target  = TAG_W'(tgt);
    endtask

    initial begin
        flush = 0; in_valid = 0; in_ex_unit = '0; in_op = '0;
        in_tag1 = '0; in_tag2 = '0; in_val1 = '0; in_val2 = '0; in_target = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_val = '0; rs_full = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        // Check the state while reset is asserted
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  0);
        check("rst_count",     count,     0);
        check("rst_out_op",    out_op,    0);
        check("rst_out_val1",  out_val1,  0);

        @(negedge clk);
        rst = 1'b1;

        // Single entry: it appears one cycle after the push and pops at once
        offer(1, 5, 0, 'h10, 0, 'h20, 3);
        #1 check("t1_in_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("t1_out_valid",  out_valid,   1);
        check("t1_out_unit",   out_ex_unit, 1);
        check("t1_out_op",     out_op,      5);
        check("t1_out_val1",   out_val1,    'h10);
        check("t1_out_val2",   out_val2,    'h20);
        check("t1_out_target", out_target,  3);
        check("t1_count1",     count,       1);
        step();
        check("t1_count0",     count,       0);
        check("t1_empty",      out_valid,   0);

        // Fill the queue while unit 2 is blocked, then drain it in order
        rs_full = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            offer(2, 10 + i, 0, 'h100 + i, 0, 0, i + 1);
            step();
        end
        offer(2, 20, 0, 0, 0, 0, 9);
        #1;
        check("t2_count_full", count,    4);
        check("t2_in_ready",   in_ready, 0);
        check("t2_head_op",    out_op,   10);
        step();
        check("t2_5th_refused", count,  4);
        check("t2_head_stable", out_op, 10);
        in_valid = 0;
        rs_full  = '0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_drain_op%0d", i),  out_op,     10 + i);
            check($sformatf("t2_drain_tgt%0d", i), out_target, i + 1);
            check($sformatf("t2_drain_v1_%0d", i), out_val1,   'h100 + i);
            step();
        end
        check("t2_drained", count, 0);

        // CDB snoop on a buffered entry (unit 3 is blocked)
        rs_full = 4'b1000;
        offer(3, 7, 0, 1, 7, 0, 5);
        step();
        in_valid = 0;
        check("t3_tag2_pending", out_tag2, 7);
        cdb_valid = 1; cdb_tag = 7; cdb_val = 'hDEAD;
        #1;
        check("t3_same_cycle_tag2", out_tag2, BYP ? 0 : 7);
        step();
        cdb_valid = 0;
        check("t3_tag2_resolved", out_tag2, 0);
        check("t3_val2_resolved", out_val2, 'hDEAD);
        cdb_valid = 1; cdb_tag = 0; cdb_val = 'hBEEF;
        step();
        cdb_valid = 0;
        check("t3_tag0_val1", out_val1, 1);
        check("t3_tag0_val2", out_val2, 'hDEAD);
        check("t3_tag0_tag1", out_tag1, 0);

        // Push coinciding with a CDB match, then an undecodable entry
        offer(3, 8, 9, 0, 0, 'h33, 6);
        cdb_valid = 1; cdb_tag = 9; cdb_val = 'h55;
        step();
        cdb_valid = 0;
        check("t4_count2", count, 2);
        offer(ERR_UNIT, 1, 0, 0, 0, 0, 0);
        #1 check("t4_err_ready", in_ready, 1);
        step();
        in_valid = 0;
        check("t4_err_dropped", count, 2);
        rs_full = '0;
        check("t4_head_op7", out_op, 7);
        step();
        check("t4_head_op8", out_op,   8);
        check("t4_res_tag1", out_tag1, 0);
        check("t4_res_val1", out_val1, 'h55);
        check("t4_val2",     out_val2, 'h33);
        step();
        check("t4_empty", count, 0);

        // Same-cycle head operand forwarding
        rs_full = 4'b1000;
        offer(3, 9, 4, 'h77, 0, 0, 2);
        step();
        in_valid = 0;
        cdb_valid = 1; cdb_tag = 4; cdb_val = 'h1;
        #1;
        check("t6_byp_tag1", out_tag1, BYP ? 0 : 4);
        check("t6_byp_val1", out_val1, BYP ? 1 : 'h77);
        step();
        cdb_valid = 0;
        check("t6_stored_tag1", out_tag1, 0);
        check("t6_stored_val1", out_val1, 1);

        // Flush with a simultaneous push and pop
        offer(3, 11, 0, 0, 0, 0, 0);
        step();
        offer(3, 12, 0, 0, 0, 0, 0);
        step();
        check("t5_count3", count, 3);
        offer(1, 13, 0, 0, 0, 0, 0);
        rs_full = '0;
        flush   = 1;
        #1 check("t5_flush_ready", in_ready, 1);
        step();
        flush = 0; in_valid = 0;
        check("t5_flush_count", count,     0);
        check("t5_flush_valid", out_valid, 0);
        step();
        check("t5_push_discarded", count, 0);

        // Back-to-back push/pop pairs that wrap the pointers
        offer(1, 40, 0, 0, 0, 0, 0);
        step();
        for (int i = 1; i <= 6; i++) begin
            offer(1, 40 + i, 0, 0, 0, 0, 0);
            #1 check($sformatf("t5_wrap_op%0d", i), out_op, 40 + i - 1);
            step();
            check($sformatf("t5_wrap_cnt%0d", i), count, 1);
        end
        in_valid = 0;
        check("t5_last_op", out_op, 46);
        step();
        check("t5_wrap_empty", count, 0);

        // Reset asserted in the middle of a burst
        rs_full = 4'b0010;
        offer(1, 50, 0, 0, 0, 0, 0);
        step();
        offer(1, 51, 0, 0, 0, 0, 0);
        step();
        in_valid = 0;
        check("t7_pre_count", count, 2);
        #2 rst = 1'b0;
        #1;
        check("t7_rst_count", count,     0);
        check("t7_rst_valid", out_valid, 0);
        check("t7_rst_op",    out_op,    0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("t7_after_count", count,     0);
        check("t7_after_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
